ex3_maxfind: RTL
================

Name: ex3_maxfind

Overview:
- Streaming max-finder, directly downstream of the ex2 4-bit `a >= b` comparator.
- Consumes framed unsigned samples over a valid/ready handshake.
- Keeps the running maximum using the same ">= wins" rule. A tie updates to the later sample.
- At the end of each frame, presents the maximum, its beat index and the beat count on a valid/ready output.

Parameters:
- WIDTH, 4: sample width in bits (unsigned).
- IDX_W, 8: width of the index and count fields; frame length is tracked up to 2^IDX_W-1 beats.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sample valid.
- in_ready  output  1  block can accept a sample.
- in_data  input  WIDTH  sample value.
- in_last  input  1  final beat of the frame.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_max  output  WIDTH  frame maximum.
- out_idx  output  IDX_W  0-based beat index of the maximum.
- out_count  output  IDX_W  number of beats in the frame.
- out_ovf  output  1  frame exceeded 2^IDX_W-1 beats.

Behaviour:
- Reset: asynchronous on rst_n=0.
  - State goes to IDLE.
  - All outputs are 0, except in_ready=1 one cycle after reset is released. in_ready is 0 while rst_n=0.
- Accept rule: a beat is accepted on a clk edge when in_valid && in_ready.
  - Transfers are independent of whether in_valid rises before or after in_ready.
- States:
  - IDLE: in_ready=1, out_valid=0. On accept: max=data, idx=0, count=1, ovf=0. If in_last, go to DONE; otherwise go to ACCUM.
  - ACCUM: in_ready=1. On accept at beat position k:
    - If data >= max: max=data, idx=k. Compare via the ge_cmp sub-module.
    - count=count+1.
    - If in_last, go to DONE.
  - DONE: in_ready=0, out_valid=1, outputs stable. When out_ready=1: go to IDLE, out_valid=0 the next cycle.
- Latency and throughput:
  - out_valid rises on the cycle after the last beat is accepted.
  - Throughput is one beat per cycle inside a frame.
  - Each frame costs at least one DONE cycle of in_ready=0.
- Saturation:
  - count saturates at 2^IDX_W-1.
  - Accepting a beat when count is already saturated sets ovf, which is sticky until the next frame starts.
  - A max update past the saturation point reports idx = all-ones.
- Simultaneous events:
  - A beat with in_valid=1 during DONE is not accepted; upstream holds it.
  - out_ready=1 while out_valid=0 is ignored.
- Reset mid-operation: a partial frame is discarded and no result is produced.
- Arithmetic: unsigned compare, zero-extended at full WIDTH; no truncation.
- in_last is ignored when the beat is not accepted.

Optional Feature:
- Macro: EX3_MINMAX_EN.
- Defined:
  - Adds output ports out_min (WIDTH) and out_min_idx (IDX_W).
  - The minimum is tracked with the rule "data <= min updates" (ties take the later beat).
  - Uses a second ge_cmp instance with its operands swapped.
  - Both are reset to 0 and held in DONE with the other outputs.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package ex3_pkg:
  - State enum {IDLE, ACCUM, DONE}.
  - Default constants WIDTH_DEF=4 and IDX_W_DEF=8.
- Sub-module ge_cmp (parameter WIDTH): combinational `a >= b`, 1-bit output. Instantiated once, or twice with EX3_MINMAX_EN.

Test Plan:
- Beats 5,3,8,1 (last on 1), out_ready=1 → out_max=8, out_idx=2, out_count=4, out_ovf=0. out_valid pulses for 1 cycle, on the cycle after the last beat.
- Tie: beats 7,2,7 → out_max=7, out_idx=2, out_count=3. With EX3_MINMAX_EN: out_min=2, out_min_idx=1.
- Single beat 0 with in_last → out_max=0, out_idx=0, out_count=1.
- Backpressure: frame 1,9, then out_ready=0 for 3 cycles → outputs stable at max=9, idx=1, in_ready=0 throughout. Then out_ready=1 → IDLE and in_ready=1 next cycle. The next frame 4 gives max=4.
- Overflow, IDX_W=2, beats 1,2,3,4,15 (last) → out_count=3, out_ovf=1, out_max=15, out_idx=3. The next frame 6 (last) gives out_ovf=0.
- Reset mid-frame: after beats 2,14 (no last), pulse rst_n low asynchronously → out_valid=0 immediately. A new frame 3 (last) gives out_max=3, out_count=1.

Source files
------------

// File: rtl/ex3_pkg.sv
// Shared types and defaults for the ex3 streaming max-finder.
package ex3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 4;
    localparam int IDX_W_DEF = 8;

endpackage

// File: rtl/ex3_maxfind_if.sv
// Sample-in / result-out handshake bundle for ex3_maxfind.
// Optional min ports are present only when EX3_MINMAX_EN is defined.
interface ex3_maxfind_if #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_max;
    logic [IDX_W-1:0] out_idx;
    logic [IDX_W-1:0] out_count;
    logic             out_ovf;
`ifdef EX3_MINMAX_EN
    logic [WIDTH-1:0] out_min;
    logic [IDX_W-1:0] out_min_idx;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_max, out_idx, out_count, out_ovf,
        input  out_min, out_min_idx
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_max, out_idx, out_count, out_ovf,
        output out_min, out_min_idx
    );
`else
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_max, out_idx, out_count, out_ovf
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_max, out_idx, out_count, out_ovf
    );
`endif
endinterface

// File: rtl/ex3_maxfind_ge_cmp.sv
// Unsigned a >= b comparator shared by the max (and optional min) trackers.
module ge_cmp #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_ge
);
    assign o_ge = (i_a >= i_b);
endmodule

// File: rtl/ex3_maxfind.sv
// Streaming frame max-finder: tracks the running maximum (ties go to the
// later beat), its beat index and the beat count, then holds the result
// until the consumer takes it. Define EX3_MINMAX_EN to also track the
// minimum with the mirrored rule.
module ex3_maxfind
    import ex3_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    ex3_maxfind_if.slave  bus
);

    localparam logic [IDX_W-1:0] CNT_SAT = '1;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_max;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_count;
    logic             r_ovf;

    logic             w_accept;
    logic             w_max_ge;
    logic             w_cnt_sat;
    logic [IDX_W-1:0] w_count_next;

    assign w_accept     = bus.in_valid && r_in_ready;
    assign w_cnt_sat    = (r_count == CNT_SAT);
    assign w_count_next = w_cnt_sat ? r_count : r_count + 1'b1;

    // New sample wins when it is >= the current maximum.
    ge_cmp #(.WIDTH(WIDTH)) u_ge_max (
        .i_a  (bus.in_data),
        .i_b  (r_max),
        .o_ge (w_max_ge)
    );

`ifdef EX3_MINMAX_EN
    logic [WIDTH-1:0] r_min;
    logic [IDX_W-1:0] r_min_idx;
    logic             w_min_ge;

    // Operands swapped: min >= data means the new sample is <= the minimum.
    ge_cmp #(.WIDTH(WIDTH)) u_ge_min (
        .i_a  (r_min),
        .i_b  (bus.in_data),
        .o_ge (w_min_ge)
    );

    // Minimum tracker, loaded on the first beat and held through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min     <= '0;
            r_min_idx <= '0;
        end else if (w_accept) begin
            if (r_state == IDLE) begin
                r_min     <= bus.in_data;
                r_min_idx <= '0;
            end else if (r_state == ACCUM && w_min_ge) begin
                r_min     <= bus.in_data;
                r_min_idx <= r_count;
            end
        end
    end

    assign bus.out_min     = r_min;
    assign bus.out_min_idx = r_min_idx;
`endif

    // Frame FSM with registered handshake outputs and max/count trackers.
    // The beat position k equals the pre-increment count; once the count
    // has saturated it stays all-ones, which is the reported idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_max       <= '0;
            r_idx       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_max   <= bus.in_data;
                        r_idx   <= '0;
                        r_count <= IDX_W'(1);
                        r_ovf   <= 1'b0;
                        if (bus.in_last) begin
                            r_state     <= DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        if (w_max_ge) begin
                            r_max <= bus.in_data;
                            r_idx <= r_count;
                        end
                        r_count <= w_count_next;
                        if (w_cnt_sat) begin
                            r_ovf <= 1'b1;
                        end
                        if (bus.in_last) begin
                            r_state     <= DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_max   = r_max;
    assign bus.out_idx   = r_idx;
    assign bus.out_count = r_count;
    assign bus.out_ovf   = r_ovf;

endmodule
